dcs_out_requant: RTL and testbench

Downstream stage of the DCSformer core. It captures each 8-word burst of 32-bit results (o_valid/o_data) into a frame buffer and finds the frame maximum and its index. It then requantizes every word to 8 bits with one per-frame right shift, so the next layer can take the results as 8-bit activations. Output is an 8-beat valid/ready stream with last, shift and argmax sideband.

---
 rtl/dcs_pkg.sv | 16 +
 rtl/dcs_msb_enc.sv | 14 +
 rtl/dcs_out_requant.sv | 88 ++++++++
 tb/tb_dcs_out_requant.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/dcs_pkg.sv
// dcs_pkg: shared sizes, FSM state type and shift-width helper for the requant stage
package dcs_pkg;
    localparam int N_WORDS = 8;
    localparam int IN_W = 32;
    localparam int OUT_W = 8;
    localparam int CNT_W = $clog2(N_WORDS);
    localparam int P_W = $clog2(IN_W + 1);

    function automatic int sh_width(input int in_w, input int out_w);
        return $clog2(in_w - out_w + 1);
    endfunction

    localparam int SH_W = sh_width(IN_W, OUT_W);

    typedef enum logic [1:0] {COLLECT, SHIFT, EMIT} state_t;
endpackage

// File: rtl/dcs_msb_enc.sv
// dcs_msb_enc: bit length of an IN_W-bit word (highest set bit index + 1, 0 for zero)
module dcs_msb_enc
    import dcs_pkg::*;
(
    input  logic [IN_W-1:0] d,
    output logic [P_W-1:0]  p
);
    // scan upward so the highest set bit wins
    always_comb begin
        p = '0;
        for (int i = 0; i < IN_W; i++)
            if (d[i]) p = P_W'(i + 1);
    end
endmodule

// File: rtl/dcs_out_requant.sv
// dcs_out_requant: buffers 8-word frames, finds max/argmax, emits 8-bit requantized beats
// Define DCS_REQUANT_ROUND_EN for round-half-up with saturation instead of truncation.
module dcs_out_requant
    import dcs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic [SH_W-1:0]  out_shift,
    output logic [CNT_W-1:0] out_argmax,
    output logic             ovf_err
);
    state_t           state;
    logic [IN_W-1:0]  mem [N_WORDS];
    logic [CNT_W-1:0] wcnt, rcnt, amax;
    logic [IN_W-1:0]  max_q;
    logic [P_W-1:0]   p;
    logic [IN_W-1:0]  word;
    logic [OUT_W-1:0] q;

    dcs_msb_enc u_enc (.d(max_q), .p(p));

    assign word = mem[rcnt];
    assign out_valid = (state == EMIT);
    assign out_last = out_valid && (rcnt == CNT_W'(N_WORDS - 1));
    assign out_data = out_valid ? q : '0;

`ifdef DCS_REQUANT_ROUND_EN
    localparam logic [IN_W:0] ONE = 1;
    logic [IN_W:0] sum;
    // round half up, then saturate anything that no longer fits OUT_W
    always_comb begin
        sum = ({1'b0, word} + (ONE << (out_shift - 1'b1))) >> out_shift;
        q = (out_shift == '0) ? word[OUT_W-1:0] : (|sum[IN_W:OUT_W]) ? '1 : sum[OUT_W-1:0];
    end
`else
    // plain truncation; the frame max bounds every result to OUT_W bits
    always_comb q = OUT_W'(word >> out_shift);
`endif

    // frame buffer: written only while collecting, so late words never corrupt it
    always_ff @(posedge clk)
        if (state == COLLECT && in_valid) mem[wcnt] <= in_data;

    // collect / shift / emit sequencing plus sticky overflow
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= COLLECT;
            wcnt       <= '0;
            rcnt       <= '0;
            max_q      <= '0;
            amax       <= '0;
            out_shift  <= '0;
            out_argmax <= '0;
            ovf_err    <= 1'b0;
        end else begin
            case (state)
                COLLECT: if (in_valid) begin
                    wcnt <= wcnt + 1'b1;
                    if (in_data > max_q) begin
                        max_q <= in_data;
                        amax  <= wcnt;
                    end
                    if (wcnt == CNT_W'(N_WORDS - 1)) state <= SHIFT;
                end
                SHIFT: begin
                    out_shift  <= (p > P_W'(OUT_W)) ? SH_W'(p - P_W'(OUT_W)) : '0;
                    out_argmax <= amax;
                    state      <= EMIT;
                end
                EMIT: if (out_ready) begin
                    rcnt <= rcnt + 1'b1;
                    if (rcnt == CNT_W'(N_WORDS - 1)) begin
                        state <= COLLECT;
                        max_q <= '0;
                        amax  <= '0;
                    end
                end
                default: state <= COLLECT;
            endcase
            if (in_valid && state != COLLECT) ovf_err <= 1'b1;
        end
endmodule

// File: tb/tb_dcs_out_requant.sv
// tb_dcs_out_requant: random and directed frames checked through an expected-beat scoreboard
module tb_dcs_out_requant;
    import dcs_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_data = '0;
    logic             out_ready = 1'b0;
    logic             out_valid, out_last, ovf_err;
    logic [OUT_W-1:0] out_data;
    logic [SH_W-1:0]  out_shift;
    logic [CNT_W-1:0] out_argmax;

    typedef struct {
        longint data;
        longint last;
        longint sh;
        longint am;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int rmode = 0;
    int ph = 0;
    logic [IN_W-1:0] f [N_WORDS];

    always #5 clk = ~clk;

    dcs_out_requant dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .out_shift(out_shift), .out_argmax(out_argmax),
        .ovf_err(ovf_err)
    );

    task automatic chk(input string n, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
        end
    endtask

    // reference: per-frame max/argmax, bit length by repeated halving, arithmetic requant
    function automatic void model(input logic [IN_W-1:0] fr [N_WORDS]);
        longint m = 0, v;
        longint am = 0, p = 0, sh;
        for (int i = 0; i < N_WORDS; i++)
            if (longint'(fr[i]) > m) begin
                m = longint'(fr[i]);
                am = i;
            end
        for (longint t = m; t > 0; t = t / 2) p++;
        sh = (p > OUT_W) ? p - OUT_W : 0;
        for (int i = 0; i < N_WORDS; i++) begin
            v = longint'(fr[i]);
`ifdef DCS_REQUANT_ROUND_EN
            if (sh > 0) v = v + (longint'(1) << (sh - 1));
            v = v >> sh;
            if (v > 255) v = 255;
`else
            v = v >> sh;
`endif
            sb.push_back('{v, (i == N_WORDS - 1) ? 1 : 0, sh, am});
        end
    endfunction

    // monitor: every presented beat must match the queue head; pop on transfer
    always @(negedge clk)
        if (rst_n && out_valid) begin
            if (sb.size() == 0) chk("stale_beat", 1, 0);
            else begin
                chk("data", out_data, sb[0].data);
                chk("last", out_last, sb[0].last);
                chk("shift", out_shift, sb[0].sh);
                chk("argmax", out_argmax, sb[0].am);
                if (out_ready) void'(sb.pop_front());
            end
        end

    // consumer: always ready, the 1,0,0,1 pattern, or random
    always @(posedge clk) begin
        #1;
        ph = (ph + 1) % 4;
        out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (ph == 0 || ph == 3) : 1'($urandom_range(0, 1));
    end

    // call in the phase just after a rising edge; returns on the first EMIT negedge
    task automatic send_frame(input bit gaps);
        model(f);
        for (int i = 0; i < N_WORDS; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data = f[i];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        @(negedge clk);
        chk("lat_shift_valid", out_valid, 0);
        @(negedge clk);
        chk("lat_emit_valid", out_valid, 1);
    endtask

    task automatic drain();
        int n = 0;
        @(posedge clk);
        #1;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_time", (n < 300) ? 1 : 0, 1);
    endtask

    task automatic rand_frame(input bit big);
        for (int i = 0; i < N_WORDS; i++) f[i] = $urandom >> $urandom_range(0, 31);
        if (big) f[$urandom_range(0, N_WORDS - 1)] = 32'hFFFF_FFFF;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 0);
        chk({tag, "_last"}, out_last, 0);
        chk({tag, "_shift"}, out_shift, 0);
        chk({tag, "_argmax"}, out_argmax, 0);
        chk({tag, "_ovf"}, ovf_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        rmode = 0;
        f = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd500, 32'd600, 32'd700, 32'd1000};
        send_frame(0);
        drain();

        f = '{default: 32'd0};
        send_frame(1);
        drain();

        rmode = 2;
        f = '{32'd5, 32'd9, 32'd9, 32'd1, 32'd0, 32'd0, 32'd0, 32'd255};
        send_frame(1);
        drain();

        f = '{32'd3, 32'd6, 32'd9, 32'd12, 32'd15, 32'd18, 32'd21, 32'd1022};
        send_frame(0);
        drain();

        rmode = 1;
        rand_frame(1);
        send_frame(0);
        drain();

        chk("ovf_before", ovf_err, 0);
        rand_frame(0);
        send_frame(1);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data = $urandom;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("ovf_set", ovf_err, 1);
        drain();
        chk("ovf_sticky", ovf_err, 1);
        rand_frame(0);
        send_frame(1);
        drain();
        chk("ovf_still", ovf_err, 1);

        rmode = 0;
        rand_frame(0);
        send_frame(0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rand_frame(0);
        send_frame(0);
        drain();

        for (int k = 0; k < 20; k++) begin
            rmode = $urandom_range(0, 2);
            rand_frame(k % 5 == 0);
            send_frame(1'($urandom_range(0, 1)));
            drain();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
